// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone B3 classic-cycle initiator. Takes one command at a time
// (address, direction, beat count) and runs a single or incrementing
// multi-beat cycle on the Wishbone bus. Write data is taken from the head of
// a show-ahead FIFO. Read data is returned one beat at a time on rsp_*.
//
// Optional feature macro: WB_MASTER_TIMEOUT_EN
//   Defined   : a beat that stalls TIMEOUT cycles without ack/err is aborted
//               exactly like a wb_err_i termination.
//   Undefined : the master waits indefinitely for ack/err.
//
// Ports
//   wb_clk_i, wb_resetn   clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_we/adr/sel/len    direction, start byte address, byte select,
//                         beats minus one
//   wdat_i, wdat_rd       write FIFO head and pop strobe
//   rsp_valid, rsp_data   one pulse per acked read beat
//   done, err             one-cycle end-of-command pulse, err on abort
//   wb_*                  Wishbone initiator signals
//   dbg_state             current FSM state (S_IDLE=0, S_BUS=1, S_END=2)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on state and reset, never
// on cmd_valid. A source that sees cmd_ready low keeps cmd_valid and the
// command fields stable until the transfer edge.
// ---------------------------------------------------------------------------
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW-1:0]     wdat_i,
  output logic              wdat_rd,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic [1:0]        dbg_state
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             we_r;
  logic [AW-1:0]    adr_r;
  logic [SW-1:0]    sel_r;
  logic [LEN_W-1:0] cnt;
  logic             err_flag;

  logic in_bus;
  logic tmo_hit;
  logic beat_ok;
  logic abort;

  assign in_bus = (state == S_BUS);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Fires on the TIMEOUT-th consecutive stalled cycle of a beat.
  assign tmo_hit = in_bus && !wb_ack_i && !wb_err_i &&
                   (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      tmo_cnt <= '0;
    end else if (!in_bus || wb_ack_i || wb_err_i) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  // A successful beat never coincides with an error; err wins over ack.
  assign beat_ok = in_bus && wb_ack_i && !wb_err_i && !tmo_hit;
  assign abort   = in_bus && (wb_err_i || tmo_hit);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_sel_o  = '0;
    wb_dat_o  = '0;
    wdat_rd   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    dbg_state = state;

    case (state)
      S_IDLE: begin
        cmd_ready = wb_resetn;
        if (cmd_valid) state_nxt = S_BUS;
      end
      S_BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_r;
        wb_adr_o = adr_r;
        wb_sel_o = sel_r;
        wb_dat_o = we_r ? wdat_i : '0;
        wdat_rd  = beat_ok && we_r;
        if (abort) begin
          state_nxt = S_END;
        end else if (beat_ok && (cnt == '0)) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        done      = 1'b1;
        err       = err_flag;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      state     <= S_IDLE;
      we_r      <= 1'b0;
      adr_r     <= '0;
      sel_r     <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= beat_ok && !we_r;
      if (beat_ok && !we_r) rsp_data <= wb_dat_i;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            we_r     <= cmd_we;
            adr_r    <= cmd_adr;
            sel_r    <= cmd_sel;
            cnt      <= cmd_len;
            err_flag <= 1'b0;
          end
        end
        S_BUS: begin
          if (abort) begin
            err_flag <= 1'b1;
          end else if (beat_ok && (cnt != '0)) begin
            // Address wraps naturally at 2^AW.
            cnt   <= cnt - 1'b1;
            adr_r <= adr_r + AW'(SW);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_wb_burst_master
//
// Drives commands into wb_burst_master, plays a Wishbone slave with random
// wait states / errors, and compares every cycle against a transaction-level
// model: beat address = base + beat*SW, cyc only while a command is on the
// bus, done one cycle after the terminating beat, read data echoed one cycle
// after its ack.
// ---------------------------------------------------------------------------
module tb_wb_burst_master;
  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int LEN_W = 8;
  localparam int SW    = DW / 8;
  localparam int TMO   = 8;

  // ---------------- clock / reset ----------------
  logic wb_clk_i  = 1'b0;
  logic wb_resetn = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic             cmd_valid = 1'b0;
  logic             cmd_we    = 1'b0;
  logic [AW-1:0]    cmd_adr   = '0;
  logic [SW-1:0]    cmd_sel   = '0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic [DW-1:0]    wdat_i    = '0;
  logic [DW-1:0]    wb_dat_i  = '0;
  logic             wb_ack_i  = 1'b0;
  logic             wb_err_i  = 1'b0;
  logic             cmd_ready, wdat_rd, rsp_valid, done, err;
  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [DW-1:0]    rsp_data, wb_dat_o;
  logic [AW-1:0]    wb_adr_o;
  logic [SW-1:0]    wb_sel_o;
  logic [1:0]       dbg_state;

  wb_burst_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_resetn(wb_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdat_i(wdat_i), .wdat_rd(wdat_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, expv);
  endtask

  // Transaction model: 0 = no command, 1 = command on bus, 2 = completion cycle
  int            m_phase     = 0;
  logic          m_we        = 1'b0;
  logic [AW-1:0] m_base      = '0;
  logic [SW-1:0] m_sel       = '0;
  int            m_len       = 0;
  int            m_beat      = 0;
  int            m_stall     = 0;
  logic          m_err       = 1'b0;
  bit            m_rst_clean = 1'b1;
  logic [DW-1:0] m_wdata[$];
  logic [DW-1:0] pend_wdata[$];
  logic [DW-1:0] wfifo[$];

  // Slave behaviour knobs
  int            sl_wmin = 0, sl_wmax = 0, sl_wait = 0;
  int            sl_err_beat = -1, sl_err_pct = 0;
  bit            sl_err_with_ack = 1'b0, sl_never = 1'b0, sl_use_fixed = 1'b0;
  logic [DW-1:0] sl_fixed = '0;
  bit            wd_fixed = 1'b0;
  logic [DW-1:0] wd_val   = '0;

  // Observed statistics for directed literal checks
  int            n_rsp = 0, n_wrd = 0, n_done = 0, n_err = 0, cyc_cycles = 0;
  logic [AW-1:0] adr_log[$];
  logic [DW-1:0] rsp_log[$];
  logic [DW-1:0] wr_log[$];

  function automatic int next_wait();
    return $urandom_range(sl_wmax, sl_wmin);
  endfunction

  // ---------------- compare + slave process ----------------
  always @(negedge wb_clk_i) begin : mon
    logic          ack_d, err_d, tmo_d;
    logic [DW-1:0] rd_d;
    logic [AW-1:0] ea;

    ea = m_base + AW'(m_beat * SW);
    chk("cmd_ready", cmd_ready, (m_phase == 0) && wb_resetn);
    chk("cyc", wb_cyc_o, m_phase == 1);
    chk("stb", wb_stb_o, m_phase == 1);
    chk("we", wb_we_o, (m_phase == 1) && m_we);
    if (m_phase == 1 || m_rst_clean) begin
      chk("adr", wb_adr_o, (m_phase == 1) ? ea : '0);
      chk("sel", wb_sel_o, (m_phase == 1) ? m_sel : '0);
    end
    chk("dat_o", wb_dat_o, (m_phase == 1 && m_we) ? m_wdata[m_beat] : '0);
    chk("done", done, m_phase == 2);
    chk("err", err, (m_phase == 2) && m_err);
    if (exp_q.size() != 0) begin
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_data", rsp_data, exp_q.pop_front());
    end else begin
      chk("rsp_valid", rsp_valid, 1'b0);
    end

    if (rsp_valid === 1'b1) begin n_rsp++; rsp_log.push_back(rsp_data); end
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
    if (wb_cyc_o === 1'b1) cyc_cycles++;

    // slave response for the coming edge
    ack_d = 1'b0;
    err_d = 1'b0;
    rd_d  = $urandom;
    if (m_phase == 1 && !sl_never) begin
      if (sl_wait > 0) begin
        sl_wait--;
      end else begin
        err_d = (m_beat == sl_err_beat) || ($urandom_range(0, 99) < sl_err_pct);
        ack_d = err_d ? (sl_err_with_ack ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
        if (sl_use_fixed) rd_d = sl_fixed;
      end
    end
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d = (m_phase == 1) && !ack_d && !err_d && (m_stall == TMO - 1);
`else
    tmo_d = 1'b0;
`endif
    wb_ack_i = ack_d;
    wb_err_i = err_d;
    wb_dat_i = rd_d;

    #1;
    chk("wdat_rd", wdat_rd, (m_phase == 1) && m_we && ack_d && !err_d && !tmo_d);
    if (wdat_rd === 1'b1) n_wrd++;

    // advance the model across the coming edge
    if (!wb_resetn) begin
      m_phase     = 0;
      m_rst_clean = 1'b1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_phase = 1; m_we = cmd_we; m_base = cmd_adr; m_sel = cmd_sel;
          m_len = int'(cmd_len); m_beat = 0; m_stall = 0; m_rst_clean = 1'b0;
          m_wdata = pend_wdata;
          sl_wait = next_wait();
        end
        1: begin
          if (err_d || tmo_d) begin
            m_phase = 2; m_err = 1'b1;
          end else if (ack_d) begin
            adr_log.push_back(wb_adr_o);
            if (m_we) wr_log.push_back(wb_dat_o);
            else exp_q.push_back(rd_d);
            if (m_beat == m_len) begin
              m_phase = 2; m_err = 1'b0;
            end else begin
              m_beat++; m_stall = 0; sl_wait = next_wait();
            end
          end else begin
            m_stall++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Show-ahead write FIFO
  always @(posedge wb_clk_i) begin
    if (wdat_rd === 1'b1 && wfifo.size() != 0) void'(wfifo.pop_front());
    wdat_i = (wfifo.size() != 0) ? wfifo[0] : '0;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_rsp = 0; n_wrd = 0; n_done = 0; n_err = 0; cyc_cycles = 0;
    adr_log.delete(); rsp_log.delete(); wr_log.delete();
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [SW-1:0] sel, input int len);
    bit acc;
    logic [DW-1:0] d;
    acc = 1'b0;
    pend_wdata.delete();
    if (we) begin
      for (int i = 0; i <= len; i++) begin
        d = (wd_fixed && i == 0) ? wd_val : DW'($urandom);
        pend_wdata.push_back(d);
        wfifo.push_back(d);
      end
    end
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge wb_clk_i);
      acc = (cmd_ready === 1'b1);
      @(posedge wb_clk_i);
      #2;
    end
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_adr   = AW'($urandom);
    cmd_len   = LEN_W'($urandom);
    chk("cmd_accept", acc, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int base;
    bit seen;
    base = n_done;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(posedge wb_clk_i);
      #2;
      seen = (n_done != base);
    end
    chk("done_seen", seen, 1'b1);
  endtask

  function automatic logic [AW-1:0] rand_adr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(0, 3) == 0) a = '1 - AW'(7 + 4 * $urandom_range(0, 3));
    a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic int rand_len();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
  endfunction

  // ---------------- main sequence ----------------
  logic [AW-1:0] t3_adr [4];
  bit found;
  int ln;

  initial begin
    t3_adr = '{26'h3F0, 26'h3F4, 26'h3F8, 26'h3FC};
    repeat (4) @(posedge wb_clk_i);
    #2 wb_resetn = 1'b1;
    @(posedge wb_clk_i); #2;

    // single write, 2 wait states
    sl_wmin = 2; sl_wmax = 2; wd_fixed = 1'b1; wd_val = 32'hDEADBEEF;
    clear_stats();
    issue(1'b1, 26'h100, 4'hF, 0);
    wait_done(40);
    wd_fixed = 1'b0;
    chk("t1_wdata", wr_log.size() != 0 ? wr_log[0] : '0, 32'hDEADBEEF);
    chk("t1_wdat_rd_cnt", n_wrd, 1);
    chk("t1_cyc_cycles", cyc_cycles, 3);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_err_cnt", n_err, 0);

    // single read
    sl_wmin = 0; sl_wmax = 0; sl_use_fixed = 1'b1; sl_fixed = 32'h12345678;
    clear_stats();
    issue(1'b0, 26'h200, 4'hF, 0);
    wait_done(40);
    sl_use_fixed = 1'b0;
    chk("t2_rsp_cnt", n_rsp, 1);
    chk("t2_rsp_data", rsp_log.size() != 0 ? rsp_log[0] : '0, 32'h12345678);
    chk("t2_cyc_cycles", cyc_cycles, 1);

    // 4-beat read with random waits
    sl_wmin = 0; sl_wmax = 3;
    clear_stats();
    issue(1'b0, 26'h3F0, 4'hF, 3);
    wait_done(60);
    chk("t3_beats", adr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_adr", i < adr_log.size() ? adr_log[i] : '0, t3_adr[i]);
    chk("t3_rsp_cnt", n_rsp, 4);

    // 3-beat write, error on beat 2
    sl_wmin = 0; sl_wmax = 1; sl_err_beat = 1; sl_err_with_ack = 1'b1;
    clear_stats();
    issue(1'b1, 26'h500, 4'h3, 2);
    wait_done(40);
    sl_err_beat = -1; sl_err_with_ack = 1'b0;
    wfifo.delete();
    chk("t4_wdat_rd_cnt", n_wrd, 1);
    chk("t4_beats", adr_log.size(), 1);
    chk("t4_done_cnt", n_done, 1);
    chk("t4_err_cnt", n_err, 1);

    // slave never answers
    sl_never = 1'b1;
    clear_stats();
    issue(1'b0, 26'h600, 4'hF, 0);
`ifdef WB_MASTER_TIMEOUT_EN
    wait_done(40);
    chk("t5_cyc_cycles", cyc_cycles, TMO);
    chk("t5_err_cnt", n_err, 1);
    chk("t5_rsp_cnt", n_rsp, 0);
`else
    repeat (1000) @(posedge wb_clk_i);
    #2;
    chk("t5_cyc_held", cyc_cycles >= 1000, 1'b1);
    chk("t5_no_done", n_done, 0);
    wb_resetn = 1'b0;
    @(posedge wb_clk_i); #2;
    wb_resetn = 1'b1;
`endif
    sl_never = 1'b0;
    @(posedge wb_clk_i); #2;

    // reset during beat 2 of a 4-beat read
    sl_wmin = 2; sl_wmax = 2;
    clear_stats();
    issue(1'b0, 26'h40, 4'hF, 3);
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(posedge wb_clk_i); #2;
      found = (m_phase == 1 && m_beat == 1);
    end
    chk("t6_reached_beat2", found, 1'b1);
    wb_resetn = 1'b0;
    @(posedge wb_clk_i); #2;
    wb_resetn = 1'b1;
    @(negedge wb_clk_i);
    chk("t6_ready_after_rst", cmd_ready, 1'b1);
    chk("t6_cyc_after_rst", wb_cyc_o, 1'b0);
    repeat (5) @(posedge wb_clk_i);
    #2;
    chk("t6_no_done", n_done, 0);
    chk("t6_rsp_cnt", n_rsp, 1);

    // random back-to-back commands, no errors
    sl_wmin = 0; sl_wmax = 3; sl_err_pct = 0;
    for (int k = 0; k < 60; k++)
      issue(1'($urandom), rand_adr(), SW'($urandom_range(1, 15)), rand_len());
    wait_done(200);
    repeat (3) @(posedge wb_clk_i);
    #2;
    chk("fifo_drained", wfifo.size(), 0);

    // random commands with errors
    sl_err_pct = 10;
    for (int k = 0; k < 60; k++) begin
      ln = rand_len();
      issue(1'($urandom), rand_adr(), SW'($urandom_range(1, 15)), ln);
      wait_done((ln + 1) * 5 + 20);
      wfifo.delete();
      repeat ($urandom_range(0, 2)) @(posedge wb_clk_i);
      #2;
    end
    sl_err_pct = 0;
    repeat (3) @(posedge wb_clk_i);
    #2;
    chk("rsp_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
